// File: rtl/memory_sequencer.sv
// ----------------------------------------------------------------------------
// memory_sequencer
//
// Runs one core-memory module through a complete destructive-read / restore
// (or clear / write) cycle on behalf of one of two requesters.
//
// Cycle shape (durations in clocks, set by parameters):
//   IDLE -> SETUP (T_SETUP) -> READ (T_READ) -> WRITE (T_WRITE)
//        -> RECOVER (T_RECOVER) -> IDLE
//
// Arbitration happens only in IDLE. On a tie the port that was not served
// most recently wins; the history flag starts at port 1, so port 0 wins the
// first tie. The granted port's address, write flag and write data are
// latched at grant, so the requester may change them freely afterwards.
//
// Ports:
//   CLK, RESET_N          clock, synchronous active-low reset
//   REQ0/WR0/ADDR0/WDATA0 port 0 (processor) request, held until ACK0
//   REQ1/WR1/ADDR1/WDATA1 port 1 (data adapter / IO) request, held until ACK1
//   ACK0, ACK1            one-cycle completion pulse for the served port
//   RDATA                 sensed word, valid with ACK and held until next ACK
//   BUSY                  high from grant through the last RECOVER cycle
//   AXVN/AYVN/AX0VN/AY0VN active-low one-hot decodes of ADDR[2:0], [5:3],
//                         [8:6], [11:9]; all-ones when not driving
//   SYNCV                 phase sync, first cycle of READ and of WRITE
//   RDMV                  read drive (whole READ phase)
//   RDMVN                 write drive (whole WRITE phase)
//   STROBV                sense strobe, last READ cycle
//   INHBV                 per-bit inhibit during WRITE (inverse of restore word)
//   SENSE                 sense-amplifier outputs, sampled on STROBV
// ----------------------------------------------------------------------------
module memory_sequencer #(
  parameter int DW        = 14,
  parameter int T_SETUP   = 1,
  parameter int T_READ    = 4,
  parameter int T_WRITE   = 4,
  parameter int T_RECOVER = 2
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          REQ0,
  input  logic          WR0,
  input  logic [11:0]   ADDR0,
  input  logic [DW-1:0] WDATA0,
  input  logic          REQ1,
  input  logic          WR1,
  input  logic [11:0]   ADDR1,
  input  logic [DW-1:0] WDATA1,
  output logic          ACK0,
  output logic          ACK1,
  output logic [DW-1:0] RDATA,
  output logic          BUSY,
  output logic [7:0]    AXVN,
  output logic [7:0]    AYVN,
  output logic [7:0]    AX0VN,
  output logic [7:0]    AY0VN,
  output logic          SYNCV,
  output logic          RDMV,
  output logic          RDMVN,
  output logic          STROBV,
  output logic [DW-1:0] INHBV,
  input  logic [DW-1:0] SENSE
);

  // Phase counter must hold the largest (duration - 1).
  localparam int T_MAX_SR = (T_SETUP > T_READ)    ? T_SETUP : T_READ;
  localparam int T_MAX_WR = (T_WRITE > T_RECOVER) ? T_WRITE : T_RECOVER;
  localparam int T_MAX    = (T_MAX_SR > T_MAX_WR) ? T_MAX_SR : T_MAX_WR;
  localparam int CW       = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] LOAD_SETUP   = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LOAD_READ    = CW'(T_READ - 1);
  localparam logic [CW-1:0] LOAD_WRITE   = CW'(T_WRITE - 1);
  localparam logic [CW-1:0] LOAD_RECOVER = CW'(T_RECOVER - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_READ,
    S_WRITE,
    S_RECOVER
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;          // cycles remaining in the current phase, minus one
  logic            gnt_port;     // port owning the cycle in flight
  logic            last_served;  // tie-break history
  logic            wr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   sense_q;      // restore register, loaded on the strobe cycle

  // Arbitration and restore selection
  logic            sel_port;
  logic [11:0]     sel_addr;
  logic            sel_wr;
  logic [DW-1:0]   sel_wdata;
  logic [DW-1:0]   restore_word;

  // Active-low one-hot decode of a 3-bit address field.
  function automatic logic [7:0] onehot_n(input logic [2:0] a);
    return ~(8'b0000_0001 << a);
  endfunction

  // NOTE: every output of this block gets a value before any condition, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sel_port = REQ1;
    if (REQ0 && REQ1) begin
      sel_port = ~last_served;
    end
    sel_addr  = sel_port ? ADDR1  : ADDR0;
    sel_wr    = sel_port ? WR1    : WR0;
    sel_wdata = sel_port ? WDATA1 : WDATA0;
    // Evaluated on the strobe edge: the sense word is being captured on that
    // same edge, so read it straight from SENSE rather than from sense_q.
    restore_word = wr_q ? wdata_q : SENSE;
  end

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every register samples the pre-edge values; later assignments in the same
  // branch simply override earlier defaults.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous and covers every register, including the
    // latched request and restore word, so an aborted cycle leaves nothing
    // behind that could leak into the next one.
    if (!RESET_N) begin
      state       <= S_IDLE;
      cnt         <= '0;
      gnt_port    <= 1'b0;
      last_served <= 1'b1;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      sense_q     <= '0;
      ACK0        <= 1'b0;
      ACK1        <= 1'b0;
      RDATA       <= '0;
      BUSY        <= 1'b0;
      AXVN        <= 8'hFF;
      AYVN        <= 8'hFF;
      AX0VN       <= 8'hFF;
      AY0VN       <= 8'hFF;
      SYNCV       <= 1'b0;
      RDMV        <= 1'b0;
      RDMVN       <= 1'b0;
      STROBV      <= 1'b0;
      INHBV       <= '0;
    end else begin
      // The strobe is registered, so the cycle it is high ends on this edge.
      if (STROBV) begin
        sense_q <= SENSE;
      end

      unique case (state)
        S_IDLE: begin
          if (REQ0 || REQ1) begin
            state       <= S_SETUP;
            cnt         <= LOAD_SETUP;
            gnt_port    <= sel_port;
            last_served <= sel_port;
            wr_q        <= sel_wr;
            wdata_q     <= sel_wdata;
            BUSY        <= 1'b1;
            AXVN        <= onehot_n(sel_addr[2:0]);
            AYVN        <= onehot_n(sel_addr[5:3]);
            AX0VN       <= onehot_n(sel_addr[8:6]);
            AY0VN       <= onehot_n(sel_addr[11:9]);
          end
        end

        S_SETUP: begin
          if (cnt == '0) begin
            state  <= S_READ;
            cnt    <= LOAD_READ;
            RDMV   <= 1'b1;
            SYNCV  <= 1'b1;
            STROBV <= (T_READ == 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_READ: begin
          SYNCV <= 1'b0;
          if (cnt == '0) begin
            state  <= S_WRITE;
            cnt    <= LOAD_WRITE;
            RDMV   <= 1'b0;
            RDMVN  <= 1'b1;
            SYNCV  <= 1'b1;
            STROBV <= 1'b0;
            // Ones are written, zeros are inhibited.
            INHBV  <= ~restore_word;
          end else begin
            cnt    <= cnt - 1'b1;
            STROBV <= (cnt == CNT_ONE);
          end
        end

        S_WRITE: begin
          SYNCV <= 1'b0;
          if (cnt == '0) begin
            state <= S_RECOVER;
            cnt   <= LOAD_RECOVER;
            RDMVN <= 1'b0;
            INHBV <= '0;
            AXVN  <= 8'hFF;
            AYVN  <= 8'hFF;
            AX0VN <= 8'hFF;
            AY0VN <= 8'hFF;
            if (T_RECOVER == 1) begin
              ACK0  <= ~gnt_port;
              ACK1  <= gnt_port;
              RDATA <= sense_q;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_RECOVER: begin
          ACK0 <= 1'b0;
          ACK1 <= 1'b0;
          if (cnt == '0) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            // Entering the final recovery cycle: report completion.
            if (cnt == CNT_ONE) begin
              ACK0  <= ~gnt_port;
              ACK1  <= gnt_port;
              RDATA <= sense_q;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_sequencer.sv
// ----------------------------------------------------------------------------
// tb_memory_sequencer
//
// Self-checking bench for memory_sequencer with default parameters.
// Requests are queued in the order they are expected to be granted; a
// negedge monitor pops the next entry when BUSY rises, checks every cycle of
// the sequence against a phase-indexed model, models the sense amplifiers,
// and checks ACK, RDATA and latency. Directed tests cover reads, writes,
// continuous contention, a request arriving mid-cycle and reset mid-cycle.
// ----------------------------------------------------------------------------
module tb_memory_sequencer;

  localparam int DW = 14;

  typedef struct {
    bit            port;
    logic [11:0]   addr;
    bit            wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] sense;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          REQ0 = 1'b0, WR0 = 1'b0, REQ1 = 1'b0, WR1 = 1'b0;
  logic [11:0]   ADDR0 = '0, ADDR1 = '0;
  logic [DW-1:0] WDATA0 = '0, WDATA1 = '0;
  logic [DW-1:0] SENSE = '0;
  logic          ACK0, ACK1, BUSY, SYNCV, RDMV, RDMVN, STROBV;
  logic [DW-1:0] RDATA, INHBV;
  logic [7:0]    AXVN, AYVN, AX0VN, AY0VN;

  memory_sequencer dut (
    .CLK(clk), .RESET_N(rst_n),
    .REQ0(REQ0), .WR0(WR0), .ADDR0(ADDR0), .WDATA0(WDATA0),
    .REQ1(REQ1), .WR1(WR1), .ADDR1(ADDR1), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .BUSY(BUSY),
    .AXVN(AXVN), .AYVN(AYVN), .AX0VN(AX0VN), .AY0VN(AY0VN),
    .SYNCV(SYNCV), .RDMV(RDMV), .RDMVN(RDMVN), .STROBV(STROBV),
    .INHBV(INHBV), .SENSE(SENSE)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  txn_t sb[$];
  txn_t cur;
  bit   cur_valid = 0;
  bit   acked = 0;
  bit   busy_d = 0;
  bit   abort_ok = 0;
  int   ph = 0;
  int   cyc = 0;
  int   syncs = 0;
  int   strobes = 0;
  int   viol = 0;
  int   last_grant_cyc = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] dec(input logic [2:0] a);
    logic [7:0] v;
    v    = 8'hFF;
    v[a] = 1'b0;
    return v;
  endfunction

  function automatic bit grp_ok(input logic [7:0] g);
    return (g == 8'hFF) || ($countones(~g) == 1);
  endfunction

  // Monitor, sense-amplifier model and protocol watch.
  always @(negedge clk) begin
    logic [31:0]   exp_grp;
    logic [5:0]    exp_ctl;
    logic [DW-1:0] exp_inh;
    cyc++;

    if ((RDMV & RDMVN) === 1'b1) viol++;
    if (rst_n && !(grp_ok(AXVN) && grp_ok(AYVN) && grp_ok(AX0VN) && grp_ok(AY0VN))) viol++;

    if (BUSY === 1'b1 && !busy_d) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", 1, 0);
        cur_valid = 0;
      end else begin
        cur       = sb.pop_front();
        cur_valid = 1;
      end
      ph = 0; syncs = 0; strobes = 0; acked = 0;
      last_grant_cyc = cyc;
    end

    if (BUSY === 1'b1 && cur_valid) begin
      ph++;
      exp_grp = (ph <= 9) ? {dec(cur.addr[2:0]), dec(cur.addr[5:3]),
                             dec(cur.addr[8:6]), dec(cur.addr[11:9])} : 32'hFFFF_FFFF;
      exp_ctl = {ph >= 2 && ph <= 5, ph >= 6 && ph <= 9, ph == 2 || ph == 6, ph == 5,
                 ph == 11 && !cur.port, ph == 11 && cur.port};
      exp_inh = (ph >= 6 && ph <= 9) ? ~(cur.wr ? cur.wdata : cur.sense) : '0;
      check("groups", {AXVN, AYVN, AX0VN, AY0VN}, exp_grp);
      check("ctrl", {RDMV, RDMVN, SYNCV, STROBV, ACK0, ACK1}, exp_ctl);
      check("inhbv", INHBV, exp_inh);
      if (SYNCV === 1'b1) syncs++;
      if (STROBV === 1'b1) strobes++;
      if ((ACK0 | ACK1) === 1'b1) begin
        acked = 1;
        check("ack_latency", ph, 11);
        check("rdata", RDATA, cur.sense);
        check("sync_count", syncs, 2);
        check("strobe_count", strobes, 1);
      end
      if (ph > 11) check("busy_too_long", ph, 11);
    end

    if (BUSY !== 1'b1 && busy_d) begin
      if (cur_valid && !acked && !abort_ok) check("busy_drop_no_ack", 0, 1);
      cur_valid = 0;
    end

    if ((ACK0 | ACK1) === 1'b1 && !(BUSY === 1'b1 && cur_valid))
      check("spurious_ack", {ACK0, ACK1}, 2'b00);

    busy_d = (BUSY === 1'b1);

    // Sense amplifiers present the stored word only during the strobe.
    if (cur_valid) SENSE = (STROBV === 1'b1) ? cur.sense : ~cur.sense;
    else           SENSE = '0;
  end

  task automatic wait_ack(input bit port, output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if ((port ? ACK1 : ACK0) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check(port ? "ack1_timeout" : "ack0_timeout", 0, 1);
  endtask

  task automatic wait_ph(input int p);
    bit hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (BUSY === 1'b1 && cur_valid && ph == p) begin
        hit = 1;
        break;
      end
    end
    if (!hit) check("phase_timeout", p, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int a0, a1, a2, a3;
    txn_t t;

    // Reset state
    @(negedge clk); #1;
    check("rst_groups", {AXVN, AYVN, AX0VN, AY0VN}, 32'hFFFF_FFFF);
    check("rst_ctrl", {ACK0, ACK1, BUSY, SYNCV, RDMV, RDMVN, STROBV}, 7'b0);
    check("rst_inhbv", INHBV, 0);
    check("rst_rdata", RDATA, 0);
    idle(1);
    rst_n = 1'b1;
    idle(2);

    // Port 0 read of 12'o1234; inputs scrambled after grant.
    REQ0 = 1; WR0 = 0; ADDR0 = 12'o1234; WDATA0 = 14'h1111;
    t = '{port: 0, addr: 12'o1234, wr: 0, wdata: 14'h1111, sense: 14'h2A5A};
    sb.push_back(t);
    wait_ph(4);
    check("t1_axvn", AXVN, 8'hEF);
    check("t1_ayvn", AYVN, 8'hF7);
    check("t1_ax0vn", AX0VN, 8'hFB);
    check("t1_ay0vn", AY0VN, 8'hFD);
    ADDR0 = 12'o0000; WR0 = 1; WDATA0 = 14'h0000;
    wait_ack(0, a0);
    REQ0 = 0;
    idle(3);

    // Port 1 write of 14'h0001 to 12'o7777.
    REQ1 = 1; WR1 = 1; ADDR1 = 12'o7777; WDATA1 = 14'h0001;
    t = '{port: 1, addr: 12'o7777, wr: 1, wdata: 14'h0001, sense: 14'h1234};
    sb.push_back(t);
    wait_ph(7);
    check("t2_inhbv", INHBV, 14'h3FFE);
    check("t2_groups", {AXVN, AYVN, AX0VN, AY0VN}, 32'h7F7F_7F7F);
    wait_ack(1, a1);
    REQ1 = 0;
    idle(3);

    // Continuous contention: grants 0,1,0,1 at a 12-cycle pitch.
    REQ0 = 1; WR0 = 0; ADDR0 = 12'o0101; REQ1 = 1; WR1 = 1; ADDR1 = 12'o2525; WDATA1 = 14'h0F0F;
    t = '{port: 0, addr: 12'o0101, wr: 0, wdata: 14'h0000, sense: 14'h3C3C}; sb.push_back(t);
    t = '{port: 1, addr: 12'o2525, wr: 1, wdata: 14'h0F0F, sense: 14'h0555}; sb.push_back(t);
    t = '{port: 0, addr: 12'o6070, wr: 1, wdata: 14'h2001, sense: 14'h1FFF}; sb.push_back(t);
    t = '{port: 1, addr: 12'o3412, wr: 0, wdata: 14'h0000, sense: 14'h0ACE}; sb.push_back(t);
    wait_ack(0, a0);
    WR0 = 1; ADDR0 = 12'o6070; WDATA0 = 14'h2001;
    wait_ack(1, a1);
    WR1 = 0; ADDR1 = 12'o3412;
    wait_ack(0, a2);
    REQ0 = 0;
    wait_ack(1, a3);
    REQ1 = 0;
    check("pitch_01", a1 - a0, 12);
    check("pitch_12", a2 - a1, 12);
    check("pitch_23", a3 - a2, 12);
    idle(3);

    // REQ0 arrives while port 1 is busy; granted on the IDLE cycle after ACK1.
    REQ1 = 1; WR1 = 1; ADDR1 = 12'o4567; WDATA1 = 14'h1C3B;
    t = '{port: 1, addr: 12'o4567, wr: 1, wdata: 14'h1C3B, sense: 14'h0F0F}; sb.push_back(t);
    t = '{port: 0, addr: 12'o0246, wr: 0, wdata: 14'h0000, sense: 14'h3333}; sb.push_back(t);
    idle(4);
    REQ0 = 1; WR0 = 0; ADDR0 = 12'o0246;
    wait_ack(1, a1);
    REQ1 = 0;
    idle(2);
    check("p0_grant_gap", last_grant_cyc - a1, 2);
    wait_ack(0, a0);
    REQ0 = 0;
    idle(3);

    // Reset during READ cycle 2 aborts without ACK; held REQ0 restarts.
    REQ0 = 1; WR0 = 0; ADDR0 = 12'o0123;
    t = '{port: 0, addr: 12'o0123, wr: 0, wdata: 14'h0000, sense: 14'h2D2D};
    sb.push_back(t);
    wait_ph(3);
    abort_ok = 1;
    rst_n = 0;
    idle(1);
    check("abort_rdmv", RDMV, 0);
    check("abort_groups", {AXVN, AYVN, AX0VN, AY0VN}, 32'hFFFF_FFFF);
    check("abort_busy", BUSY, 0);
    check("abort_ack", {ACK0, ACK1}, 2'b00);
    sb.push_back(t);
    idle(1);
    rst_n = 1;
    abort_ok = 0;
    wait_ack(0, a0);
    REQ0 = 0;
    idle(3);

    check("protocol_violations", viol, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/memory_sequencer.md
Name: memory_sequencer

Overview:
- Sequences one core-memory module through a full read/restore or clear/write cycle.
- Arbitrates the module between two requesters: port 0 (processor) and port 1 (data adapter/IO).
- Latches the granted 12-bit address and drives the four active-low one-hot X/Y decoder groups.
- Generates the SYNC, read-drive (RDMV/RDMVN), sense-strobe and per-bit inhibit controls, captures sensed data and returns it with an acknowledge.

Parameters:
- DW, 14, data word width (sense/inhibit bits).
- T_SETUP, 1, cycles address drives settle before read current.
- T_READ, 4, cycles of read drive; the sense strobe is on the last of these.
- T_WRITE, 4, cycles of write drive with inhibit applied.
- T_RECOVER, 2, cycles of quiet recovery; ack is on the last of these.
- (All T_* are ≥1.)

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  synchronous, active-low reset.
- REQ0  in  1  port 0 request; held high until ACK0.
- WR0  in  1  port 0: 1 = write WDATA0, 0 = read/restore.
- ADDR0  in  12  port 0 word address.
- WDATA0  in  DW  port 0 write data.
- REQ1/WR1/ADDR1/WDATA1  in  1/1/12/DW  same, port 1.
- ACK0, ACK1  out  1  one-cycle completion pulse per port.
- RDATA  out  DW  captured read word; valid while ACK0/ACK1 is high and held until the next capture.
- BUSY  out  1  high from grant through the last RECOVER cycle.
- AXVN  out  8  active-low one-hot of ADDR[2:0].
- AYVN  out  8  active-low one-hot of ADDR[5:3].
- AX0VN  out  8  active-low one-hot of ADDR[8:6].
- AY0VN  out  8  active-low one-hot of ADDR[11:9].
- SYNCV  out  1  phase sync pulse.
- RDMV  out  1  read drive.
- RDMVN  out  1  write drive.
- STROBV  out  1  sense strobe.
- INHBV  out  DW  per-bit inhibit drive.
- SENSE  in  DW  sense-amplifier outputs, sampled on STROBV.

Behaviour:
- All outputs are registered.
- Reset values: ACK0/ACK1/BUSY/SYNCV/RDMV/RDMVN/STROBV = 0; INHBV = 0; RDATA = 0; all address groups = 8'hFF; state = IDLE.
- States and durations: IDLE -> SETUP (T_SETUP) -> READ (T_READ) -> WRITE (T_WRITE) -> RECOVER (T_RECOVER) -> IDLE. A down-counter loads the duration on each state entry.
- Arbitration, in IDLE only:
  - Only one requester high: grant it.
  - Both high: grant the port not served most recently. The last-served flag resets to port 1, so port 0 wins the first tie.
  - Grant latches ADDR, WR and WDATA of the granted port. Later changes on that port's inputs are ignored until its ACK.
- Address drive: the four groups drive the one-hot decode of the latched address from SETUP through WRITE. They are 8'hFF in IDLE and RECOVER. Exactly one bit per group is low while driven.
- READ:
  - RDMV = 1 throughout.
  - SYNCV = 1 on the first READ cycle only.
  - STROBV = 1 on the last READ cycle only; SENSE is captured into an internal restore register on that cycle.
- WRITE:
  - RDMVN = 1 throughout.
  - SYNCV = 1 on the first WRITE cycle only.
  - Restore source is latched WDATA if WR = 1, else the captured sense word.
  - INHBV = ~restore word for all WRITE cycles, so zero bits are inhibited. INHBV = 0 outside WRITE.
- RDMV and RDMVN are never high together.
- RECOVER: on its last cycle, pulse ACK of the granted port for one cycle. On that cycle RDATA = captured sense word (for reads and writes alike) and BUSY drops next cycle.
- Latency: grant edge to ACK = T_SETUP+T_READ+T_WRITE+T_RECOVER cycles (11 default). At least one IDLE cycle separates cycles, so the back-to-back period is 12.
- A requester that drops REQ before ACK does not abort the cycle. ACK still pulses and the requester ignores it.
- Reset low mid-cycle: next edge forces all reset values, and no ACK is issued for the aborted cycle.

Test Plan:
- Port 0 read, ADDR0=12'o1234, SENSE=14'h2A5A at strobe:
  - AXVN=8'hEF, AYVN=8'hF7, AX0VN=8'hFB, AY0VN=8'hFD.
  - STROBV exactly 1 cycle, on READ cycle 4.
  - INHBV=~14'h2A5A during all 4 WRITE cycles.
  - ACK0 11 cycles after grant with RDATA=14'h2A5A.
- Port 1 write, ADDR1=12'o7777, WDATA1=14'h0001:
  - All groups =8'h7F.
  - INHBV=14'h3FFE during WRITE.
  - ACK1 only; ACK0 stays 0.
- REQ0 and REQ1 both held continuously:
  - Grants alternate 0,1,0,1.
  - ACKs are 12 cycles apart.
  - SYNCV pulses exactly twice per cycle.
- REQ0 rises while a port 1 cycle is BUSY: no effect on the current cycle; port 0 is granted on the IDLE cycle after ACK1.
- RESET_N low on READ cycle 2:
  - Next edge: RDMV=0, groups=8'hFF, BUSY=0.
  - No ACK is issued.
  - After release, a held REQ0 starts a fresh full cycle.
- Protocol checks asserted throughout: RDMV&RDMVN never 1; each driven group has exactly one low bit.
